pcf8591_adc_reader: RTL and testbench

- I2C master that reads one 8-bit conversion from a PCF8591 ADC channel. It is the read-direction counterpart of the team's PCF8591 DAC write path.
- Sequence: START, address+W, control byte, repeated START, address+R, then two data bytes, STOP.
- The first data byte is the stale previous conversion and is discarded. The second byte is returned.
- Sits between board logic (buttons/switches, 7-seg display) and the shared PCF8591 SDA/SCL pins.

---
 rtl/pcf8591_adc_reader.sv | 177 +++++++++++++++++
 tb/tb_pcf8591_adc_reader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pcf8591_adc_reader.sv
// I2C master that performs one PCF8591 ADC read: write the control byte, repeated START,
// read two bytes, keep the second (the first is the stale previous conversion).
module pcf8591_adc_reader #(
    parameter int unsigned CLK_DIV  = 1000,
    parameter logic [6:0]  DEV_ADDR = 7'b1001000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] channel,
    output logic       busy,
    output logic       valid,
    output logic       nack_err,
    output logic [7:0] data,
    output logic       scl,
    inout  wire        sda
);
    localparam int unsigned    PW     = $clog2(CLK_DIV);
    localparam logic [PW-1:0]  P_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0]  P_HALF = PW'(CLK_DIV / 2);
    localparam logic [PW-1:0]  P_Q1   = PW'(CLK_DIV / 4);
    localparam logic [PW-1:0]  P_Q3   = PW'((3 * CLK_DIV) / 4);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_WADDR, S_WACK, S_CTRL, S_CACK, S_RSTART,
        S_RADDR, S_RACK, S_RD0, S_MACK, S_RD1, S_MNACK, S_STOP
    } state_t;

    state_t         state_r;
    state_t         next_state_s;
    logic [PW-1:0]  p_r;
    logic [PW-1:0]  p_next_s;
    logic           p_wrap_s;
    logic [2:0]     bit_r;
    logic [1:0]     ch_r;
    logic [7:0]     shift_r;
    logic           nack_r;
    logic           busy_r;
    logic           valid_r;
    logic           nack_err_r;
    logic [7:0]     data_r;
    logic           scl_r;
    logic           sda_low_r;
    logic [7:0]     tx_byte_s;
    logic           tx_bit_s;
    logic           byte_state_s;
    logic           q1_low_s;
    logic           q3_low_s;

    assign busy     = busy_r;
    assign valid    = valid_r;
    assign nack_err = nack_err_r;
    assign data     = data_r;
    assign scl      = scl_r;
    assign sda      = sda_low_r ? 1'b0 : 1'bz;

    // Phase counter advance and the outgoing bit of the byte currently being written.
    always_comb begin
        p_wrap_s = (p_r == P_LAST);
        if (p_wrap_s) begin
            p_next_s = '0;
        end else begin
            p_next_s = p_r + 1'b1;
        end
        case (state_r)
            S_WADDR: tx_byte_s = {DEV_ADDR, 1'b0};
            S_CTRL:  tx_byte_s = {6'b000000, ch_r};
            S_RADDR: tx_byte_s = {DEV_ADDR, 1'b1};
            default: tx_byte_s = 8'hFF;
        endcase
        tx_bit_s = tx_byte_s[3'd7 - bit_r];
    end

    // Next state at a bit-period boundary; a NACK in any ACK slot diverts to STOP.
    always_comb begin
        byte_state_s = 1'b0;
        case (state_r)
            S_START:  next_state_s = S_WADDR;
            S_WADDR:  next_state_s = (bit_r == 3'd7) ? S_WACK : S_WADDR;
            S_WACK:   next_state_s = nack_r ? S_STOP : S_CTRL;
            S_CTRL:   next_state_s = (bit_r == 3'd7) ? S_CACK : S_CTRL;
            S_CACK:   next_state_s = nack_r ? S_STOP : S_RSTART;
            S_RSTART: next_state_s = S_RADDR;
            S_RADDR:  next_state_s = (bit_r == 3'd7) ? S_RACK : S_RADDR;
            S_RACK:   next_state_s = nack_r ? S_STOP : S_RD0;
            S_RD0:    next_state_s = (bit_r == 3'd7) ? S_MACK : S_RD0;
            S_MACK:   next_state_s = S_RD1;
            S_RD1:    next_state_s = (bit_r == 3'd7) ? S_MNACK : S_RD1;
            S_MNACK:  next_state_s = S_STOP;
            S_STOP:   next_state_s = S_IDLE;
            default:  next_state_s = S_IDLE;
        endcase
        case (state_r)
            S_WADDR, S_CTRL, S_RADDR, S_RD0, S_RD1: byte_state_s = 1'b1;
            default:                                byte_state_s = 1'b0;
        endcase
    end

    // SDA level to present at mid-low (data / MACK / STOP setup) and at mid-high (START, STOP edges).
    always_comb begin
        case (state_r)
            S_WADDR, S_CTRL, S_RADDR: q1_low_s = ~tx_bit_s;
            S_MACK, S_STOP:           q1_low_s = 1'b1;
            default:                  q1_low_s = 1'b0;
        endcase
        case (state_r)
            S_START, S_RSTART: q3_low_s = 1'b1;
            S_STOP:            q3_low_s = 1'b0;
            default:           q3_low_s = sda_low_r;
        endcase
    end

    // Transaction FSM; outputs are computed from the next phase so scl/sda line up with p.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            p_r        <= '0;
            bit_r      <= 3'd0;
            ch_r       <= 2'd0;
            shift_r    <= 8'h00;
            nack_r     <= 1'b0;
            busy_r     <= 1'b0;
            valid_r    <= 1'b0;
            nack_err_r <= 1'b0;
            data_r     <= 8'h00;
            scl_r      <= 1'b1;
            sda_low_r  <= 1'b0;
        end else begin
            valid_r    <= 1'b0;
            nack_err_r <= 1'b0;
            if (!busy_r) begin
                p_r       <= '0;
                scl_r     <= 1'b1;
                sda_low_r <= 1'b0;
                if (start) begin
                    busy_r  <= 1'b1;
                    state_r <= S_START;
                    ch_r    <= channel;
                    bit_r   <= 3'd0;
                    nack_r  <= 1'b0;
                    scl_r   <= 1'b0;
                end
            end else begin
                p_r   <= p_next_s;
                scl_r <= (p_next_s >= P_HALF);
                if (p_next_s == P_Q1) begin
                    sda_low_r <= q1_low_s;
                end else if (p_next_s == P_Q3) begin
                    sda_low_r <= q3_low_s;
                end
                if (p_r == P_Q3) begin
                    case (state_r)
                        S_WACK, S_CACK, S_RACK: nack_r  <= sda;
                        S_RD0, S_RD1:           shift_r <= {shift_r[6:0], sda};
                        default:                shift_r <= shift_r;
                    endcase
                end
                if (p_wrap_s) begin
                    state_r <= next_state_s;
                    bit_r   <= byte_state_s ? (bit_r + 3'd1) : 3'd0;
                    // End of the STOP period: report and return to idle in the same edge.
                    if (state_r == S_STOP) begin
                        busy_r    <= 1'b0;
                        scl_r     <= 1'b1;
                        sda_low_r <= 1'b0;
                        if (nack_r) begin
                            nack_err_r <= 1'b1;
                        end else begin
                            valid_r <= 1'b1;
                            data_r  <= shift_r;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_pcf8591_adc_reader.sv
// Bench for pcf8591_adc_reader: behavioural I2C slave, bus monitor and completion scoreboard.
module tb_pcf8591_adc_reader;
    localparam int CD = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] channel = 2'd0;
    logic       busy, valid, nack_err, scl;
    logic [7:0] data;
    wire        sda;
    logic       bfm_low = 1'b0;

    assign sda = bfm_low ? 1'b0 : 1'bz;
    pullup (sda);

    pcf8591_adc_reader #(.CLK_DIV(CD), .DEV_ADDR(7'b1001000)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .channel(channel), .busy(busy),
        .valid(valid), .nack_err(nack_err), .data(data), .scl(scl), .sda(sda)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- slave model ----------------
    int         edge_n = 100;
    bit         tx_mode = 1'b0, pend_tx = 1'b0, first = 1'b0;
    logic       mack = 1'b0;
    logic [7:0] sh = 8'h00, txb = 8'h00;
    logic [7:0] txq[$];
    logic [7:0] seen[$];
    logic       macks[$];
    int         nack_at_g = -1;

    task automatic bfm_arm(input int nack_at, input logic [7:0] r0, input logic [7:0] r1);
        nack_at_g = nack_at;
        txq.delete(); txq.push_back(r0); txq.push_back(r1);
        seen.delete(); macks.delete();
    endtask

    always @(negedge sda) if (scl === 1'b1) begin
        edge_n = 0; tx_mode = 1'b0; pend_tx = 1'b0; first = 1'b1;
    end
    always @(posedge sda) if (scl === 1'b1) begin
        edge_n = 100; tx_mode = 1'b0;
    end
    always @(posedge scl) begin
        if (edge_n < 8) begin
            if (!tx_mode) sh = {sh[6:0], sda};
            edge_n++;
        end else if (edge_n == 8) begin
            if (tx_mode) begin mack = sda; macks.push_back(sda); end
            edge_n++;
        end
    end
    always @(negedge scl) begin
        if (edge_n == 8) begin
            if (!tx_mode) begin
                seen.push_back(sh);
                bfm_low = ((int'(seen.size()) - 1) != nack_at_g);
                if (first && sh[0] && bfm_low) pend_tx = 1'b1;
                first = 1'b0;
            end else begin
                bfm_low = 1'b0;
            end
        end else if (edge_n == 9) begin
            edge_n = 0;
            if (pend_tx) begin tx_mode = 1'b1; pend_tx = 1'b0; mack = 1'b0; end
            if (tx_mode && !mack && txq.size() > 0) begin
                txb = txq.pop_front();
                bfm_low = !txb[7];
            end else begin
                bfm_low = 1'b0;
            end
        end else if (tx_mode && edge_n >= 1 && edge_n <= 7) begin
            bfm_low = !txb[7 - edge_n];
        end
    end

    // ---------------- bus monitor ----------------
    logic prev_scl = 1'b1, prev_sda = 1'b1;
    int   n_fall = 0, n_rise = 0, busy_cnt = 0;
    always @(negedge clk) begin
        if (prev_scl === 1'b1 && scl === 1'b1 && sda !== prev_sda) begin
            if (sda === 1'b0) n_fall++; else n_rise++;
        end
        if (bfm_low && sda !== 1'b0) begin
            n_miss++;
            $display("FAIL sda_contention: got %b expected 0 (cycle %0d)", sda, cyc);
        end
        if (busy) busy_cnt++;
        prev_scl = scl; prev_sda = sda;
    end

    // ---------------- scoreboard ----------------
    typedef struct { bit ok; logic [7:0] data; int cyc; } exp_t;
    exp_t sbq[$];
    exp_t sb_e;
    int   n_valid = 0, n_nack = 0;
    always @(negedge clk) begin
        if (rst_n && (valid || nack_err)) begin
            if (valid) n_valid++;
            if (nack_err) n_nack++;
            if (sbq.size() == 0) begin
                n_miss++;
                $display("FAIL sb_unexpected: got valid=%b nack_err=%b expected none", valid, nack_err);
            end else begin
                sb_e = sbq.pop_front();
                chk("sb_kind", {31'd0, valid}, {31'd0, sb_e.ok});
                chk("sb_excl", {31'd0, valid & nack_err}, 32'd0);
                chk("sb_cycle", cyc, sb_e.cyc);
                chk("sb_busy", {31'd0, busy}, 32'd0);
                if (sb_e.ok) chk("sb_data", {24'd0, data}, {24'd0, sb_e.data});
            end
        end
    end

    task automatic run_txn(input logic [1:0] ch, input logic [7:0] r0, input logic [7:0] r1,
                           input int nack_at, input logic [7:0] exp_data, input int mid_at);
        int periods, nb, t, guard;
        logic [7:0] exp_b [3];
        exp_t e;
        periods = (nack_at == 0) ? 11 : (nack_at == 1) ? 20 : (nack_at == 2) ? 30 : 48;
        nb = (nack_at < 0) ? 3 : nack_at + 1;
        exp_b[0] = 8'h90; exp_b[1] = {6'b000000, ch}; exp_b[2] = 8'h91;
        @(negedge clk);
        bfm_arm(nack_at, r0, r1);
        n_fall = 0; n_rise = 0; busy_cnt = 0; n_valid = 0; n_nack = 0;
        start = 1'b1; channel = ch; t = cyc;
        e.ok = (nack_at < 0); e.data = exp_data; e.cyc = t + 1 + periods * CD;
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (busy && guard < periods * CD + 40) begin
            if (mid_at != 0 && guard == mid_at) begin start = 1'b1; channel = 2'd3; end
            else start = 1'b0;
            @(negedge clk);
            guard++;
        end
        start = 1'b0;
        chk("timeout_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        chk("busy_cycles", busy_cnt, periods * CD);
        chk("n_bytes", seen.size(), nb);
        for (int i = 0; i < nb && i < int'(seen.size()); i++)
            chk("byte_seen", {24'd0, seen[i]}, {24'd0, exp_b[i]});
        chk("valid_pulses", n_valid, (nack_at < 0) ? 1 : 0);
        chk("nack_pulses", n_nack, (nack_at < 0) ? 0 : 1);
        chk("data", {24'd0, data}, {24'd0, exp_data});
        chk("starts", n_fall, (nack_at < 0 || nack_at == 2) ? 2 : 1);
        chk("stops", n_rise, 1);
        if (nack_at < 0) begin
            chk("n_macks", macks.size(), 2);
            if (macks.size() == 2) begin
                chk("mack_rd0", {31'd0, macks[0]}, 32'd0);
                chk("mnack_rd1", {31'd0, macks[1]}, 32'd1);
            end
        end
        chk("sb_drained", sbq.size(), 0);
    endtask

    typedef struct { logic [1:0] ch; logic [7:0] r0; logic [7:0] r1; int nack_at; logic [7:0] exp_data; } vec_t;
    vec_t vecs [7];

    initial begin
        int t;
        vecs[0] = '{2'd2, 8'h11, 8'hA7, -1, 8'hA7};
        vecs[1] = '{2'd0, 8'h22, 8'h5C,  0, 8'hA7};
        vecs[2] = '{2'd1, 8'h33, 8'h3C,  1, 8'hA7};
        vecs[3] = '{2'd3, 8'h44, 8'hFF, -1, 8'hFF};
        vecs[4] = '{2'd1, 8'h00, 8'h00,  2, 8'hFF};
        vecs[5] = '{2'd0, 8'h55, 8'h01, -1, 8'h01};
        vecs[6] = '{2'd1, 8'h80, 8'hC3, -1, 8'hC3};

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_nack", {31'd0, nack_err}, 32'd0);
        chk("rst_data", {24'd0, data}, 32'd0);
        chk("rst_scl", {31'd0, scl}, 32'd1);
        chk("rst_sda", {31'd0, sda}, 32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_scl", {31'd0, scl}, 32'd1);

        for (int i = 0; i < 7; i++)
            run_txn(vecs[i].ch, vecs[i].r0, vecs[i].r1, vecs[i].nack_at, vecs[i].exp_data, 0);

        // start with channel 3 pulsed mid-transfer must be ignored
        run_txn(2'd2, 8'h66, 8'hA7, -1, 8'hA7, 100);

        // asynchronous reset in the middle of RD1, then a clean transfer
        @(negedge clk);
        bfm_arm(-1, 8'h12, 8'h5A);
        start = 1'b1; channel = 2'd1; t = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < t + 1 + 40 * CD + 2) @(negedge clk);
        chk("pre_rst_scl", {31'd0, scl}, 32'd0);
        bfm_low = 1'b0; edge_n = 100; tx_mode = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_scl", {31'd0, scl}, 32'd1);
        chk("arst_sda", {31'd0, sda}, 32'd1);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_data", {24'd0, data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(2'd1, 8'h77, 8'h6E, -1, 8'h6E, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
